rtl_rr_arbiter: RTL and testbench

//  - Shares one registered xor/or-reduce/and-reduce datapath (the RTL_unq1 function) between NREQ ready/valid requesters.
//  - Each requester offers an operand pair (in1, in2). A round-robin arbiter grants one requester per cycle.
//  - The result is issued on a single ready/valid output channel, tagged with the source id.
//  - Sits between the handshake_arr_* producers and the single downstream consumer on handshake_*.

---
 rtl/rtl_rr_arbiter_pkg.sv | 23 ++
 rtl/rtl_rr_picker.sv | 34 +++
 rtl/rtl_rr_arbiter.sv | 121 ++++++++++++
 tb/tb_rtl_rr_arbiter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/rtl_rr_arbiter_pkg.sv
// Shared types and the xor/or-reduce/and-reduce datapath function for the round-robin arbiter.
package rtl_arb_pkg;

  localparam int unsigned NREQ_DEF = 3;
  localparam int unsigned W_DEF    = 5;

  typedef logic [W_DEF-1:0] operand_t;

  typedef struct packed {
    operand_t xr;
    logic     orr;
    logic     andr;
  } result_t;

  function automatic result_t compute(input operand_t in1, input operand_t in2);
    result_t r;
    r.xr   = in1 ^ in2;
    r.orr  = |r.xr;
    r.andr = &r.xr;
    return r;
  endfunction

endpackage

// File: rtl/rtl_rr_picker.sv
// Combinational rotate-priority-rotate picker: first asserted req at or after ptr, modulo NREQ.
module rtl_rr_picker #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic             found;
  logic [IDX_W-1:0] k_idx;
  int unsigned      k;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    k         = 0;
    k_idx     = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      k = 32'(ptr) + j;
      if (k >= NREQ) k = k - NREQ;
      k_idx = IDX_W'(k);
      if (!found && req[k_idx]) begin
        found     = 1'b1;
        grant_idx = k_idx;
      end
    end
    if (found) grant = NREQ'(1) << grant_idx;
  end

endmodule

// File: rtl/rtl_rr_arbiter.sv
// Round-robin arbiter sharing one registered xor/orr/andr datapath among NREQ ready/valid requesters.
// Define RTL_RR_ARBITER_CHECK_EN to compile in protocol/fairness assertions and an accept trace.
module rtl_rr_arbiter
  import rtl_arb_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned W     = W_DEF,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     CLK,
  input  logic                     ASYNCRESET,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*W-1:0]        req_in1,
  input  logic [NREQ*W-1:0]        req_in2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_xor,
  output logic                     out_orr,
  output logic                     out_andr,
  output logic [$clog2(NREQ)-1:0]  out_id,
  output logic [CNT_W-1:0]         issue_cnt
);

  localparam int unsigned IDX_W = $clog2(NREQ);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] grant_idx;
  logic [NREQ-1:0]  grant;
  logic             can_load;
  logic             accept;
  logic [W-1:0]     sel_in1, sel_in2;
  logic [W-1:0]     xr_d;
  logic             orr_d, andr_d;

  assign out_valid = (state_q == FULL);
  assign can_load  = !out_valid || out_ready;

  rtl_rr_picker #(.NREQ(NREQ), .IDX_W(IDX_W)) u_picker (
    .req       (can_load ? req_valid : '0),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |grant;
  assign sel_in1   = req_in1[grant_idx*W +: W];
  assign sel_in2   = req_in2[grant_idx*W +: W];

  // Default width goes through the shared package function; other widths use the same equations.
  if (W == W_DEF) begin : g_pkg_dp
    result_t res;
    assign res    = compute(operand_t'(sel_in1), operand_t'(sel_in2));
    assign xr_d   = res.xr;
    assign orr_d  = res.orr;
    assign andr_d = res.andr;
  end else begin : g_gen_dp
    assign xr_d   = sel_in1 ^ sel_in2;
    assign orr_d  = |xr_d;
    assign andr_d = &xr_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (out_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_q   <= EMPTY;
      ptr_q     <= '0;
      issue_cnt <= '0;
      out_xor   <= '0;
      out_orr   <= 1'b0;
      out_andr  <= 1'b0;
      out_id    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ptr_q     <= (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        issue_cnt <= issue_cnt + CNT_W'(1);
        out_xor   <= xr_d;
        out_orr   <= orr_d;
        out_andr  <= andr_d;
        out_id    <= grant_idx;
      end
    end
  end

`ifdef RTL_RR_ARBITER_CHECK_EN
  a_onehot_ready: assert property (@(posedge CLK) disable iff (ASYNCRESET) $onehot0(req_ready));

  a_stable_out: assert property (@(posedge CLK) disable iff (ASYNCRESET)
    out_valid && !out_ready |=> $stable({out_xor, out_orr, out_andr, out_id}));

  // Per requester: accepts that went to others while this one was continuously valid.
  for (genvar i = 0; i < NREQ; i++) begin : g_fair
    logic [IDX_W:0] wait_cnt;
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
      if (ASYNCRESET)                      wait_cnt <= '0;
      else if (!req_valid[i] || grant[i])  wait_cnt <= '0;
      else if (accept)                     wait_cnt <= wait_cnt + (IDX_W+1)'(1);
    end
    a_fair: assert property (@(posedge CLK) disable iff (ASYNCRESET)
      32'(wait_cnt) < NREQ);
  end

  always @(posedge CLK) begin
    if (!ASYNCRESET && accept) $display("%x %x", grant_idx, xr_d);
  end
`endif

endmodule

// File: tb/tb_rtl_rr_arbiter.sv
// Directed table-driven bench for rtl_rr_arbiter plus reset, round-robin and counter-wrap sequences.
module tb_rtl_rr_arbiter;

  logic        CLK = 1'b0;
  logic        ASYNCRESET;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready, w_req_ready;
  logic [14:0] req_in1, req_in2;
  logic        out_valid, w_out_valid;
  logic        out_ready;
  logic [4:0]  out_xor, w_out_xor;
  logic        out_orr, w_out_orr;
  logic        out_andr, w_out_andr;
  logic [1:0]  out_id, w_out_id;
  logic [15:0] issue_cnt;
  logic [3:0]  w_issue_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  rtl_rr_arbiter #(.NREQ(3), .W(5), .CNT_W(16)) dut (
    .CLK(CLK), .ASYNCRESET(ASYNCRESET), .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .out_valid(out_valid), .out_ready(out_ready),
    .out_xor(out_xor), .out_orr(out_orr), .out_andr(out_andr), .out_id(out_id),
    .issue_cnt(issue_cnt)
  );

  rtl_rr_arbiter #(.NREQ(3), .W(5), .CNT_W(4)) u_wrap (
    .CLK(CLK), .ASYNCRESET(ASYNCRESET), .req_valid(req_valid), .req_ready(w_req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_xor(w_out_xor), .out_orr(w_out_orr), .out_andr(w_out_andr), .out_id(w_out_id),
    .issue_cnt(w_issue_cnt)
  );

  typedef struct {
    logic [2:0]  rv;
    logic [14:0] in1;
    logic [14:0] in2;
    logic        ordy;
    logic [2:0]  rdy;
    logic        v;
    logic [4:0]  x;
    logic        orr;
    logic        andr;
    logic [1:0]  id;
    logic [15:0] cnt;
  } vec_t;

  localparam int NV = 19;
  localparam logic [14:0] RI1 = {5'h03, 5'h02, 5'h01};
  localparam logic [14:0] RI2 = 15'h0;

  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] rv, input logic [14:0] i1, input logic [14:0] i2,
                       input logic ordy);
    req_valid = rv;
    req_in1   = i1;
    req_in2   = i2;
    out_ready = ordy;
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #3;
    ASYNCRESET = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_issue_cnt", 32'(issue_cnt), 32'd0);
    @(posedge CLK);
    #1;
    ASYNCRESET = 1'b0;
  endtask

  initial begin
    ASYNCRESET = 1'b1;
    drive(3'b000, 15'h0, 15'h0, 1'b1);

    // rv, in1, in2, ordy | rdy, v, xor, orr, andr, id, cnt
    vecs[0]  = '{3'b010, {5'h00, 5'h1F, 5'h00}, {5'h00, 5'h0A, 5'h00}, 1'b1, 3'b010, 1'b1, 5'h15, 1'b1, 1'b0, 2'd1, 16'd1};
    vecs[1]  = '{3'b010, {5'h00, 5'h0C, 5'h00}, {5'h00, 5'h0C, 5'h00}, 1'b1, 3'b010, 1'b1, 5'h00, 1'b0, 1'b0, 2'd1, 16'd2};
    vecs[2]  = '{3'b010, {5'h00, 5'h00, 5'h00}, {5'h00, 5'h1F, 5'h00}, 1'b1, 3'b010, 1'b1, 5'h1F, 1'b1, 1'b1, 2'd1, 16'd3};
    vecs[3]  = '{3'b000, 15'h0, 15'h0, 1'b1, 3'b000, 1'b0, 5'h1F, 1'b1, 1'b1, 2'd1, 16'd3};
    vecs[4]  = '{3'b000, 15'h0, 15'h0, 1'b0, 3'b000, 1'b0, 5'h1F, 1'b1, 1'b1, 2'd1, 16'd3};
    vecs[5]  = '{3'b111, RI1, RI2, 1'b1, 3'b100, 1'b1, 5'h03, 1'b1, 1'b0, 2'd2, 16'd4};
    vecs[6]  = '{3'b111, RI1, RI2, 1'b1, 3'b001, 1'b1, 5'h01, 1'b1, 1'b0, 2'd0, 16'd5};
    vecs[7]  = '{3'b111, RI1, RI2, 1'b1, 3'b010, 1'b1, 5'h02, 1'b1, 1'b0, 2'd1, 16'd6};
    vecs[8]  = '{3'b111, RI1, RI2, 1'b1, 3'b100, 1'b1, 5'h03, 1'b1, 1'b0, 2'd2, 16'd7};
    vecs[9]  = '{3'b111, RI1, RI2, 1'b1, 3'b001, 1'b1, 5'h01, 1'b1, 1'b0, 2'd0, 16'd8};
    vecs[10] = '{3'b111, RI1, RI2, 1'b1, 3'b010, 1'b1, 5'h02, 1'b1, 1'b0, 2'd1, 16'd9};
    vecs[11] = '{3'b111, RI1, RI2, 1'b0, 3'b000, 1'b1, 5'h02, 1'b1, 1'b0, 2'd1, 16'd9};
    vecs[12] = '{3'b111, RI1, RI2, 1'b0, 3'b000, 1'b1, 5'h02, 1'b1, 1'b0, 2'd1, 16'd9};
    vecs[13] = '{3'b111, RI1, RI2, 1'b0, 3'b000, 1'b1, 5'h02, 1'b1, 1'b0, 2'd1, 16'd9};
    vecs[14] = '{3'b111, RI1, RI2, 1'b0, 3'b000, 1'b1, 5'h02, 1'b1, 1'b0, 2'd1, 16'd9};
    vecs[15] = '{3'b111, RI1, RI2, 1'b1, 3'b100, 1'b1, 5'h03, 1'b1, 1'b0, 2'd2, 16'd10};
    vecs[16] = '{3'b110, RI1, RI2, 1'b1, 3'b010, 1'b1, 5'h02, 1'b1, 1'b0, 2'd1, 16'd11};
    vecs[17] = '{3'b011, RI1, RI2, 1'b1, 3'b001, 1'b1, 5'h01, 1'b1, 1'b0, 2'd0, 16'd12};
    vecs[18] = '{3'b000, RI1, RI2, 1'b1, 3'b000, 1'b0, 5'h01, 1'b1, 1'b0, 2'd0, 16'd12};

    @(posedge CLK);
    #1;
    chk("init_out_valid", 32'(out_valid), 32'd0);
    chk("init_out_xor",   32'(out_xor),   32'd0);
    chk("init_out_id",    32'(out_id),    32'd0);
    chk("init_issue_cnt", 32'(issue_cnt), 32'd0);
    ASYNCRESET = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rv, vecs[i].in1, vecs[i].in2, vecs[i].ordy);
      #1;
      chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].rdy));
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].v));
      chk($sformatf("v%0d_out_xor", i),   32'(out_xor),   32'(vecs[i].x));
      chk($sformatf("v%0d_out_orr", i),   32'(out_orr),   32'(vecs[i].orr));
      chk($sformatf("v%0d_out_andr", i),  32'(out_andr),  32'(vecs[i].andr));
      chk($sformatf("v%0d_out_id", i),    32'(out_id),    32'(vecs[i].id));
      chk($sformatf("v%0d_issue_cnt", i), 32'(issue_cnt), 32'(vecs[i].cnt));
    end

    // Fresh reset, then all three valid for six cycles: ids 0,1,2,0,1,2.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(3'b111, RI1, RI2, 1'b1);
      @(posedge CLK);
      #1;
      chk($sformatf("rr%0d_out_id", k),  32'(out_id),  32'(k % 3));
      chk($sformatf("rr%0d_out_xor", k), 32'(out_xor), 32'((k % 3) + 1));
    end
    chk("rr_issue_cnt", 32'(issue_cnt), 32'd6);

    // Reset while a result is pending drops out_valid before the next edge.
    chk("mid_out_valid_pre", 32'(out_valid), 32'd1);
    do_reset();

    // Sixteen accepts wrap the 4-bit counter back to zero.
    for (int k = 0; k < 16; k++) begin
      drive(3'b001, {5'h00, 5'h00, 5'h05}, {5'h00, 5'h00, 5'h06}, 1'b1);
      @(posedge CLK);
      #1;
      if (k == 14) chk("wrap_cnt_allones", 32'(w_issue_cnt), 32'd15);
    end
    chk("wrap_cnt_zero",   32'(w_issue_cnt), 32'd0);
    chk("wrap_out_valid",  32'(w_out_valid), 32'd1);
    chk("wrap_out_xor",    32'(w_out_xor),   32'h03);
    chk("wrap_main_cnt",   32'(issue_cnt),   32'd16);
    drive(3'b000, 15'h0, 15'h0, 1'b1);
    @(posedge CLK);
    #1;
    chk("wrap_drain_valid", 32'(w_out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
